// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// PC source codes and the bundle of pipeline control outputs.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MD_WAIT   = 2'd1,
    ST_EXC_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_EXC = 2'b10,
    PCSEL_EPC = 2'b11
  } pc_sel_e;

  typedef struct packed {
    logic    pc_write;
    pc_sel_e pc_sel;
    logic    if_id_stall;
    logic    if_id_flush;
    logic    id_ex_stall;
    logic    id_ex_flush;
    logic    ex_mem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{pc_write: 1'b1, pc_sel: PCSEL_SEQ, default: 1'b0};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-condition inputs and pipeline-control outputs of the hazard
// controller; slave is the controller, master is the pipeline datapath.
interface pipeline_hazard_ctrl_if;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt;
  logic       EX_BranchTaken;
  logic       EX_MD_Start;
  logic       MEM_Exception;
  logic       MEM_eret;
  logic       PC_Write;
  logic [1:0] PC_Sel;
  logic       IF_ID_Stall;
  logic       IF_ID_Flush;
  logic       ID_EX_Stall;
  logic       ID_EX_Flush;
  logic       EX_MEM_Flush;
  logic       Busy;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_EX_MemRead, ID_EX_Rt,
           EX_BranchTaken, EX_MD_Start, MEM_Exception, MEM_eret,
    input  PC_Write, PC_Sel, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall,
           ID_EX_Flush, EX_MEM_Flush, Busy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_EX_MemRead, ID_EX_Rt,
           EX_BranchTaken, EX_MD_Start, MEM_Exception, MEM_eret,
    output PC_Write, PC_Sel, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall,
           ID_EX_Flush, EX_MEM_Flush, Busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Combinational load-use detector: the ID instruction reads a register
// that the load currently in EX has not yet written.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       lu
);

  // $zero never carries a real dependency, so a load targeting it is harmless.
  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rt)) ||
               (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritised
// exception > branch > mult/div > load-use, with Mealy control outputs.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int EXC_DRAIN  = 2
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CNT_W = $clog2(max_int(MD_LATENCY, EXC_DRAIN) + 1);
  localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] EXC_LOAD = CNT_W'(EXC_DRAIN - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;
  logic             redirect;
  ctrl_t            ctrl;

  load_use_detect u_lu (
    .id_rs       (hz.ID_Rs),
    .id_rt       (hz.ID_Rt),
    .id_uses_rs  (hz.ID_UsesRs),
    .id_uses_rt  (hz.ID_UsesRt),
    .ex_mem_read (hz.ID_EX_MemRead),
    .ex_rt       (hz.ID_EX_Rt),
    .lu          (lu)
  );

  assign redirect = hz.MEM_Exception || hz.MEM_eret;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first in every combinational process so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RUN: begin
        if (redirect) begin
          state_nxt = ST_EXC_DRAIN;
          cnt_nxt   = EXC_LOAD;
        end else if (!hz.EX_BranchTaken && hz.EX_MD_Start) begin
          state_nxt = ST_MD_WAIT;
          cnt_nxt   = MD_LOAD;
        end
      end
      ST_MD_WAIT: begin
        // A redirect aborts the mult/div outright; it is never resumed.
        if (redirect) begin
          state_nxt = ST_EXC_DRAIN;
          cnt_nxt   = EXC_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_EXC_DRAIN: begin
        if (cnt == '0) state_nxt = ST_RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    if (reset) begin
      ctrl = '0;
    end else begin
      unique case (state)
        ST_RUN, ST_MD_WAIT: begin
          if (redirect) begin
            ctrl.pc_sel       = hz.MEM_Exception ? PCSEL_EXC : PCSEL_EPC;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
          end else if (state == ST_MD_WAIT) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
          end else if (hz.EX_BranchTaken) begin
            ctrl.pc_sel      = PCSEL_BR;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (!hz.EX_MD_Start && lu) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end
        end
        ST_EXC_DRAIN: begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_flush  = 1'b1;
          ctrl.ex_mem_flush = 1'b1;
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign hz.PC_Write     = ctrl.pc_write;
  assign hz.PC_Sel       = ctrl.pc_sel;
  assign hz.IF_ID_Stall  = ctrl.if_id_stall;
  assign hz.IF_ID_Flush  = ctrl.if_id_flush;
  assign hz.ID_EX_Stall  = ctrl.id_ex_stall;
  assign hz.ID_EX_Flush  = ctrl.id_ex_flush;
  assign hz.EX_MEM_Flush = ctrl.ex_mem_flush;
  assign hz.Busy         = !reset && (state != ST_RUN);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (MD_LATENCY 4 and 32) share
// stimulus and are compared against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 2;

  // Output vector order: PC_Write, PC_Sel[1:0], IF_ID_Stall, IF_ID_Flush,
  // ID_EX_Stall, ID_EX_Flush, EX_MEM_Flush, Busy.
  localparam logic [8:0] V_RST    = 9'b0_00_0_0_0_0_0_0;
  localparam logic [8:0] V_IDLE   = 9'b1_00_0_0_0_0_0_0;
  localparam logic [8:0] V_LU     = 9'b0_00_1_0_0_1_0_0;
  localparam logic [8:0] V_BR     = 9'b1_01_0_1_0_1_0_0;
  localparam logic [8:0] V_MDW    = 9'b0_00_1_0_1_0_1_1;
  localparam logic [8:0] V_EXC    = 9'b1_10_0_1_0_1_1_0;
  localparam logic [8:0] V_EXC_MD = 9'b1_10_0_1_0_1_1_1;
  localparam logic [8:0] V_ERET   = 9'b1_11_0_1_0_1_1_0;
  localparam logic [8:0] V_DRN    = 9'b0_00_0_1_0_1_1_1;

  // Stimulus code bits: reset, branch, md_start, exception, eret, load-use.
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_RST  = 6'b100000;
  localparam logic [5:0] S_BR   = 6'b010000;
  localparam logic [5:0] S_MD   = 6'b001000;
  localparam logic [5:0] S_EXC  = 6'b000100;
  localparam logic [5:0] S_ERET = 6'b000010;
  localparam logic [5:0] S_LU   = 6'b000001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       uses_rs, uses_rt, mem_read, br, md_start, exc, eret;

  int checks = 0;
  int errors = 0;

  int md_left   [2] = '{0, 0};
  int drain_left[2] = '{0, 0};
  int lat       [2] = '{4, 32};

  pipeline_hazard_ctrl_if if4 ();
  pipeline_hazard_ctrl_if if32 ();

  assign if4.ID_Rs = id_rs;            assign if32.ID_Rs = id_rs;
  assign if4.ID_Rt = id_rt;            assign if32.ID_Rt = id_rt;
  assign if4.ID_UsesRs = uses_rs;      assign if32.ID_UsesRs = uses_rs;
  assign if4.ID_UsesRt = uses_rt;      assign if32.ID_UsesRt = uses_rt;
  assign if4.ID_EX_MemRead = mem_read; assign if32.ID_EX_MemRead = mem_read;
  assign if4.ID_EX_Rt = ex_rt;         assign if32.ID_EX_Rt = ex_rt;
  assign if4.EX_BranchTaken = br;      assign if32.EX_BranchTaken = br;
  assign if4.EX_MD_Start = md_start;   assign if32.EX_MD_Start = md_start;
  assign if4.MEM_Exception = exc;      assign if32.MEM_Exception = exc;
  assign if4.MEM_eret = eret;          assign if32.MEM_eret = eret;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .EXC_DRAIN(DRAIN)) dut4 (
    .clk (clk), .reset (reset), .hz (if4)
  );
  pipeline_hazard_ctrl #(.MD_LATENCY(32), .EXC_DRAIN(DRAIN)) dut32 (
    .clk (clk), .reset (reset), .hz (if32)
  );

  wire [8:0] obs4  = {if4.PC_Write, if4.PC_Sel, if4.IF_ID_Stall, if4.IF_ID_Flush,
                      if4.ID_EX_Stall, if4.ID_EX_Flush, if4.EX_MEM_Flush, if4.Busy};
  wire [8:0] obs32 = {if32.PC_Write, if32.PC_Sel, if32.IF_ID_Stall, if32.IF_ID_Flush,
                      if32.ID_EX_Stall, if32.ID_EX_Flush, if32.EX_MEM_Flush, if32.Busy};

  always #5 clk = ~clk;

  // Reference model: an instance is frozen while it has mult/div stall
  // cycles or drain cycles left; otherwise the prioritised rules apply.
  function automatic bit lu_ref();
    return mem_read && (ex_rt != 5'd0) &&
           ((uses_rs && id_rs == ex_rt) || (uses_rt && id_rt == ex_rt));
  endfunction

  function automatic logic [8:0] model_out(input int k);
    bit busy = (md_left[k] > 0) || (drain_left[k] > 0);
    if (reset)                  return V_RST;
    if (drain_left[k] > 0)      return V_DRN;
    if (exc)                    return {1'b1, 2'b10, 5'b01011, busy};
    if (eret)                   return {1'b1, 2'b11, 5'b01011, busy};
    if (md_left[k] > 0)         return V_MDW;
    if (br)                     return V_BR;
    if (!md_start && lu_ref())  return V_LU;
    return V_IDLE;
  endfunction

  task automatic advance();
    int nm[2];
    int nd[2];
    for (int k = 0; k < 2; k++) begin
      nm[k] = md_left[k];
      nd[k] = drain_left[k];
      if (reset) begin
        nm[k] = 0; nd[k] = 0;
      end else if (drain_left[k] > 0) begin
        nd[k] = drain_left[k] - 1;
      end else if (exc || eret) begin
        nd[k] = DRAIN; nm[k] = 0;
      end else if (md_left[k] > 0) begin
        nm[k] = md_left[k] - 1;
      end else if (!br && md_start) begin
        nm[k] = lat[k];
      end
    end
    @(posedge clk);
    md_left = nm;
    drain_left = nd;
    #1;
  endtask

  task automatic apply(input logic [5:0] s);
    reset    = s[5];
    br       = s[4];
    md_start = s[3];
    exc      = s[2];
    eret     = s[1];
    mem_read = s[0];
    ex_rt    = s[0] ? 5'd8 : 5'd0;
    id_rs    = s[0] ? 5'd8 : 5'd0;
    uses_rs  = s[0];
    id_rt    = 5'd0;
    uses_rt  = 1'b0;
  endtask

  task automatic settle();
    apply(S_NONE);
    for (int i = 0; i < 40; i++) begin
      #4;
      checks++;
      if ({obs4, obs32} !== {model_out(0), model_out(1)}) begin
        errors++;
        $display("FAIL settle cyc%0d: got %b/%b want %b/%b", i, obs4, obs32, model_out(0), model_out(1));
      end
      advance();
    end
  endtask

  task automatic test_reset();
    apply(S_RST);
    advance();
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if ({obs4, obs32} !== {2{V_RST}}) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b/%b want %b", i, obs4, obs32, V_RST);
      end
      advance();
    end
    apply(S_NONE);
    #4;
    checks++;
    if ({obs4, obs32} !== {2{V_IDLE}}) begin
      errors++;
      $display("FAIL reset_release: got %b/%b want %b", obs4, obs32, V_IDLE);
    end
    advance();
  endtask

  task automatic test_load_use();
    apply(S_LU);
    #4;
    checks++;
    if ({obs4, obs32} !== {2{V_LU}}) begin
      errors++;
      $display("FAIL load_use: got %b/%b want %b", obs4, obs32, V_LU);
    end
    advance();
    apply(S_LU);
    ex_rt = 5'd0;
    id_rs = 5'd0;
    #4;
    checks++;
    if ({obs4, obs32} !== {2{V_IDLE}}) begin
      errors++;
      $display("FAIL load_use_r0: got %b/%b want %b", obs4, obs32, V_IDLE);
    end
    advance();
    apply(S_NONE);
    #4;
    checks++;
    if ({obs4, obs32} !== {2{V_IDLE}}) begin
      errors++;
      $display("FAIL load_use_one_bubble: got %b/%b want %b", obs4, obs32, V_IDLE);
    end
    advance();
  endtask

  task automatic test_branch_lu();
    apply(S_BR | S_LU | S_MD);
    #4;
    checks++;
    if ({obs4, obs32} !== {2{V_BR}}) begin
      errors++;
      $display("FAIL branch_lu: got %b/%b want %b", obs4, obs32, V_BR);
    end
    advance();
    apply(S_NONE);
    #4;
    checks++;
    if ({obs4, obs32} !== {2{V_IDLE}}) begin
      errors++;
      $display("FAIL branch_no_md: got %b/%b want %b", obs4, obs32, V_IDLE);
    end
    advance();
  endtask

  task automatic test_mult_div();
    logic [5:0] st [7];
    logic [8:0] ex [7];
    st = '{S_MD, S_LU, S_BR, S_NONE, S_NONE, S_NONE, S_NONE};
    ex = '{V_IDLE, V_MDW, V_MDW, V_MDW, V_MDW, V_IDLE, V_IDLE};
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      #4;
      checks++;
      if (obs4 !== ex[i]) begin
        errors++;
        $display("FAIL mult_div cyc%0d: got %b want %b", i, obs4, ex[i]);
      end
      checks++;
      if ({obs4, obs32} !== {model_out(0), model_out(1)}) begin
        errors++;
        $display("FAIL mult_div_model cyc%0d: got %b/%b want %b/%b", i, obs4, obs32, model_out(0), model_out(1));
      end
      advance();
    end
    settle();
  endtask

  task automatic test_exc_in_md();
    logic [5:0] st [7];
    logic [8:0] ex [7];
    st = '{S_MD, S_NONE, S_EXC, S_NONE, S_NONE, S_NONE, S_NONE};
    ex = '{V_IDLE, V_MDW, V_EXC_MD, V_DRN, V_DRN, V_IDLE, V_IDLE};
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      #4;
      checks++;
      if ({obs4, obs32} !== {ex[i], ex[i]}) begin
        errors++;
        $display("FAIL exc_in_md cyc%0d: got %b/%b want %b", i, obs4, obs32, ex[i]);
      end
      advance();
    end
  endtask

  task automatic test_exc_eret();
    logic [5:0] st [12];
    logic [8:0] ex [12];
    st = '{S_EXC | S_ERET, S_NONE, S_NONE, S_NONE,
           S_ERET, S_NONE, S_NONE, S_NONE,
           S_EXC, S_EXC, S_ERET | S_EXC, S_NONE};
    ex = '{V_EXC, V_DRN, V_DRN, V_IDLE,
           V_ERET, V_DRN, V_DRN, V_IDLE,
           V_EXC, V_DRN, V_DRN, V_IDLE};
    for (int i = 0; i < 12; i++) begin
      apply(st[i]);
      #4;
      checks++;
      if ({obs4, obs32} !== {ex[i], ex[i]}) begin
        errors++;
        $display("FAIL exc_eret cyc%0d: got %b/%b want %b", i, obs4, obs32, ex[i]);
      end
      advance();
    end
  endtask

  task automatic test_reset_in_md();
    logic [5:0] st [4];
    logic [8:0] ex [4];
    st = '{S_MD, S_RST, S_NONE, S_NONE};
    ex = '{V_IDLE, V_RST, V_IDLE, V_IDLE};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      #4;
      checks++;
      if ({obs4, obs32} !== {ex[i], ex[i]}) begin
        errors++;
        $display("FAIL reset_in_md cyc%0d: got %b/%b want %b", i, obs4, obs32, ex[i]);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(63) == 0);
      exc      = ($urandom_range(24) == 0);
      eret     = ($urandom_range(24) == 0);
      br       = ($urandom_range(5) == 0);
      md_start = ($urandom_range(9) == 0);
      mem_read = $urandom_range(1);
      uses_rs  = $urandom_range(1);
      uses_rt  = $urandom_range(1);
      id_rs    = 5'($urandom_range(3));
      id_rt    = 5'($urandom_range(3));
      ex_rt    = 5'($urandom_range(3));
      #4;
      checks++;
      if ({obs4, obs32} !== {model_out(0), model_out(1)}) begin
        errors++;
        $display("FAIL random cyc%0d: got %b/%b want %b/%b", i, obs4, obs32, model_out(0), model_out(1));
      end
      advance();
    end
    settle();
  endtask

  initial begin
    apply(S_RST);
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mult_div();
    test_exc_in_md();
    test_exc_eret();
    test_reset_in_md();
    settle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the stall and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers, plus PC write enable and PC source select. It resolves four conditions in one prioritized FSM:
- load-use hazards
- taken branches resolved in EX
- multi-cycle mult/div occupancy
- exception/eret redirects from MEM

## Interface
Parameters:
- MD_LATENCY, 32, cycles a mult/div occupies EX (minimum 2)
- EXC_DRAIN, 2, post-redirect cycles with fetch frozen for CP0 settling (minimum 1)

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- ID_Rs, ID_Rt  in  5 each  source register fields of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1 each  ID instruction actually reads Rs/Rt
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rt  in  5  load destination register in EX
- EX_BranchTaken  in  1  branch/jump in EX redirects
- EX_MD_Start  in  1  mult/div entering execution this cycle (single-cycle pulse)
- MEM_Exception  in  1  syscall/RI/overflow detected in MEM
- MEM_eret  in  1  eret in MEM
- PC_Write  out  1  PC register enable
- PC_Sel  out  2  PC source: 00 sequential, 01 branch target, 10 exception vector, 11 EPC
- IF_ID_Stall, IF_ID_Flush  out  1 each  IF/ID register controls
- ID_EX_Stall, ID_EX_Flush  out  1 each  ID/EX register controls
- EX_MEM_Flush  out  1  inserts a bubble into EX/MEM
- Busy  out  1  FSM not in RUN

## Operation
- States: RUN, MD_WAIT, EXC_DRAIN. Counter `cnt` has width clog2(max(MD_LATENCY, EXC_DRAIN)+1).
- Outputs are Mealy: a function of the registered state and the current inputs. Controls apply in the same cycle as the condition.
- Idle outputs in RUN with no condition: PC_Write=1, PC_Sel=00, all other outputs 0.
- Load-use condition, lu: ID_EX_MemRead && ID_EX_Rt!=0 && ((ID_UsesRs && ID_Rs==ID_EX_Rt) || (ID_UsesRt && ID_Rt==ID_EX_Rt)).
- Priority, highest first: exception/eret > branch > mult/div > load-use.
- Exception/eret, accepted in RUN or MD_WAIT:
  - Outputs: PC_Write=1, PC_Sel=10 (MEM_Exception) or 11 (MEM_eret only); IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1.
  - Next state: cnt<=EXC_DRAIN-1, go to EXC_DRAIN. In MD_WAIT this aborts the mult/div.
  - If both MEM_Exception and MEM_eret are high, MEM_Exception wins.
- Branch in RUN:
  - Outputs: PC_Write=1, PC_Sel=01, IF_ID_Flush=1, ID_EX_Flush=1.
  - Overrides lu; EX_MD_Start in the same cycle is ignored.
- EX_MD_Start in RUN (no exception, no branch): cnt<=MD_LATENCY-1, go to MD_WAIT. Outputs that cycle are idle.
- MD_WAIT:
  - Outputs: PC_Write=0, IF_ID_Stall=1, ID_EX_Stall=1, EX_MEM_Flush=1.
  - cnt decrements each cycle. When cnt==0, return to RUN at the next edge; outputs in that final cycle remain stall.
  - lu and branch inputs are ignored.
- lu in RUN (no higher-priority condition): PC_Write=0, IF_ID_Stall=1, ID_EX_Flush=1. No state change; the stall repeats while lu holds.
- EXC_DRAIN:
  - Outputs: PC_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1.
  - cnt decrements; when cnt==0, return to RUN.
  - All inputs are ignored, including new exceptions, because the pipeline is empty.
- Busy = (state != RUN).

## Timing
- While reset is high, at the edge: state<=RUN, cnt<=0.
- Outputs during reset cycles: PC_Write=0, PC_Sel=00, all stalls/flushes 0, Busy=0.
- Reset mid-MD_WAIT or mid-EXC_DRAIN abandons the sequence; RUN is entered at the next edge.
- Mult/div latency:
  - The EX_MD_Start cycle plus MD_LATENCY stall cycles.
  - The pipeline advances again in the (MD_LATENCY+1)th cycle after the start.
- Exception redirect: 1 redirect cycle plus EXC_DRAIN frozen cycles. The first fetch of the handler is latched into IF/ID EXC_DRAIN+1 cycles after the redirect.
- Load-use: exactly one bubble per hazard occurrence.

## Structure
- Shared package:
  - state encoding (RUN=2'd0, MD_WAIT=2'd1, EXC_DRAIN=2'd2)
  - PC_Sel codes (PCSEL_SEQ, PCSEL_BR, PCSEL_EXC, PCSEL_EPC)
- Sub-module: load_use_detect, purely combinational, produces lu. Everything else stays in one FSM module (about 150–250 lines).

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, ID_Rs=8, ID_UsesRs=1 for one cycle -> PC_Write=0, IF_ID_Stall=1, ID_EX_Flush=1 that cycle. Repeat with ID_EX_Rt=0 -> idle outputs.
- Branch and load-use together: EX_BranchTaken=1 with lu true -> PC_Sel=01, PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, IF_ID_Stall=0.
- Mult/div, MD_LATENCY=4: pulse EX_MD_Start -> Busy=1 and stalls held for exactly 4 cycles with EX_MEM_Flush=1; then RUN with idle outputs.
- Exception during MD_WAIT at stall cycle 2:
  - Expected: PC_Sel=10 with all three flushes, then EXC_DRAIN for 2 cycles with PC_Write=0, then RUN.
  - The mult/div stall does not resume.
- MEM_Exception and MEM_eret together -> PC_Sel=10. MEM_eret alone -> PC_Sel=11. An exception during EXC_DRAIN -> ignored, drain length unchanged.
- Reset asserted in cycle 1 of MD_WAIT (MD_LATENCY=32) -> all outputs reset values. After deassertion, state is RUN and Busy=0 with idle outputs.
